// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RAM arbiter and its surroundings: CPU data port,
// external master (loader/debug/DMA) port and the single-port data RAM.
// slave  : arbiter view
// master : environment view (CPU, external master and RAM model)
interface ram_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
);
   logic              cpu_en;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              ext_req;
   logic              ext_we;
   logic              ext_lock;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_ack;
   logic [DATA_W-1:0] ext_rdata;

   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
      output ext_ack, ext_rdata,
      output ram_addr, ram_wdata, ram_we,
      input  ram_rdata
   );

   modport master (
      output cpu_en, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
      input  ext_ack, ext_rdata,
      input  ram_addr, ram_wdata, ram_we,
      output ram_rdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between the CPU data port and
// one external master. The CPU has priority; the external master is granted
// on idle CPU cycles, or forcibly after MAX_WAIT starved cycles (CPU stalled
// for that cycle). MAX_WAIT = 0 disables the forced grant.
//
// Optional feature macro: RAM_ARB_BURST_EN
//   defined     : ext_lock keeps the grant for up to BURST_MAX back-to-back accesses
//   not defined : ext_lock ignored, every external grant lasts exactly one cycle
//
// owner   | meaning
// OWN_CPU | RAM muxed to the CPU, external master waits
// OWN_EXT | RAM muxed to the external master, CPU stalled if it requests
module ram_arbiter #(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 16,
   parameter int MAX_WAIT  = 4,
   parameter int BURST_MAX = 8
) (
   input logic          clk,
   input logic          reset,
   ram_arbiter_if.slave bus
);
   typedef enum logic {OWN_CPU = 1'b0, OWN_EXT = 1'b1} owner_t;

   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      (MAX_WAIT == 0) ? WAIT_W'(0) : WAIT_W'(MAX_WAIT - 1);

   if (BURST_MAX < 1) begin : g_bad_burst_max
      $error("ram_arbiter: BURST_MAX must be >= 1");
   end

   owner_t            owner;
   logic [WAIT_W-1:0] wait_cnt;
   logic              force_grant;
   logic              ext_sel;
   logic              ext_ack_int;
   logic              ram_we_int;
   logic              cpu_stall_int;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;

`ifdef RAM_ARB_BURST_EN
   localparam int BURST_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);
   logic [BURST_W-1:0] burst_cnt;
`else
   logic unused_lock;
   assign unused_lock = bus.ext_lock;
`endif

   assign force_grant = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);

   // Mux RAM to the current owner; strobes are forced inactive while reset is low.
   always_comb begin
      ext_sel       = (owner == OWN_EXT);
      addr_mux      = ext_sel ? bus.ext_addr  : bus.cpu_addr;
      wdata_mux     = ext_sel ? bus.ext_wdata : bus.cpu_wdata;
      ram_we_int    = reset & (ext_sel ? (bus.ext_req & bus.ext_we)
                                       : (bus.cpu_en & bus.cpu_we));
      ext_ack_int   = reset & ext_sel & bus.ext_req;
      cpu_stall_int = reset & ext_sel & bus.cpu_en;
   end

   assign bus.ram_addr  = addr_mux;
   assign bus.ram_wdata = wdata_mux;
   assign bus.ram_we    = ram_we_int;
   assign bus.ext_ack   = ext_ack_int;
   assign bus.cpu_stall = cpu_stall_int;
   assign bus.cpu_rdata = bus.ram_rdata;
   assign bus.ext_rdata = bus.ram_rdata;

   // Ownership FSM with starvation counter (and burst counter when enabled).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner    <= OWN_CPU;
         wait_cnt <= '0;
`ifdef RAM_ARB_BURST_EN
         burst_cnt <= '0;
`endif
      end else if (owner == OWN_CPU) begin
         if (bus.ext_req && (!bus.cpu_en || force_grant)) begin
            owner    <= OWN_EXT;
            wait_cnt <= '0;
         end else if (bus.ext_req) begin
            // CPU busy and ext starving: count, saturate rather than wrap
            if (wait_cnt != {WAIT_W{1'b1}}) begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end else begin
            wait_cnt <= '0;
         end
      end else begin
         wait_cnt <= '0;
`ifdef RAM_ARB_BURST_EN
         if (ext_ack_int && bus.ext_lock && (burst_cnt < BURST_LAST)) begin
            burst_cnt <= burst_cnt + 1'b1;
         end else begin
            owner     <= OWN_CPU;
            burst_cnt <= '0;
         end
`else
         owner <= OWN_CPU;
`endif
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter. Main DUT uses MAX_WAIT=4; a second DUT with
// MAX_WAIT=0 shares the same stimulus to show that it never forces a grant.
module tb_ram_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   ram_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus ();
   ram_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus_nw ();

   ram_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_WAIT(4), .BURST_MAX(8)) dut (
      .clk(clk), .reset(rst_n), .bus(bus));

   ram_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_WAIT(0), .BURST_MAX(8)) dut_nw (
      .clk(clk), .reset(rst_n), .bus(bus_nw));

   assign bus_nw.cpu_en    = bus.cpu_en;
   assign bus_nw.cpu_we    = bus.cpu_we;
   assign bus_nw.cpu_addr  = bus.cpu_addr;
   assign bus_nw.cpu_wdata = bus.cpu_wdata;
   assign bus_nw.ext_req   = bus.ext_req;
   assign bus_nw.ext_we    = bus.ext_we;
   assign bus_nw.ext_lock  = bus.ext_lock;
   assign bus_nw.ext_addr  = bus.ext_addr;
   assign bus_nw.ext_wdata = bus.ext_wdata;
   assign bus_nw.ram_rdata = 16'h0000;

   // small RAM model, cleared on the first clock edge
   logic [15:0] mem [0:255];
   logic        mem_ready = 1'b0;
   assign bus.ram_rdata = mem[bus.ram_addr[7:0]];

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         mem_ready <= 1'b1;
      end else if (bus.ram_we) begin
         mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_cpu(input logic en, input logic we, input logic [14:0] addr,
                          input logic [15:0] wdata);
      bus.cpu_en = en; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
   endtask

   task automatic set_ext(input logic req, input logic we, input logic lock,
                          input logic [14:0] addr, input logic [15:0] wdata);
      bus.ext_req = req; bus.ext_we = we; bus.ext_lock = lock;
      bus.ext_addr = addr; bus.ext_wdata = wdata;
   endtask

   logic        exp_ack;
   logic        ack_now;
   logic [19:0] hist;
   logic [19:0] exp_hist;
   logic [7:0]  exp_n;
   logic [14:0] last_addr;
   logic [15:0] last_data;
   logic [1:0]  req_pat [0:7];
   int          n;

   initial begin
      rst_n = 1'b0;
      set_cpu(1'b1, 1'b1, 15'h0005, 16'hAAAA);
      set_ext(1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
      @(negedge clk);

      // 1: reset held with CPU writing -> all strobes suppressed
      #1;
      check("rst_ram_we", 32'(bus.ram_we), 32'h0);
      check("rst_stall", 32'(bus.cpu_stall), 32'h0);
      check("rst_ext_ack", 32'(bus.ext_ack), 32'h0);
      tick();
      rst_n = 1'b1;
      #1;
      check("cpu_wr_we", 32'(bus.ram_we), 32'h1);
      check("cpu_wr_addr", 32'(bus.ram_addr), 32'h5);
      tick();
      set_cpu(1'b1, 1'b0, 15'h0005, 16'h0000);
      #1;
      check("cpu_rd_data", 32'(bus.cpu_rdata), 32'hAAAA);
      check("cpu_rd_stall", 32'(bus.cpu_stall), 32'h0);
      tick();

      // 2: idle CPU, ext write 0x1234 @ 0x0010 -> ack on second cycle
      set_cpu(1'b0, 1'b0, 15'h0000, 16'h0000);
      set_ext(1'b1, 1'b1, 1'b0, 15'h0010, 16'h1234);
      #1;
      check("t2_ack_c1", 32'(bus.ext_ack), 32'h0);
      check("t2_we_c1", 32'(bus.ram_we), 32'h0);
      tick();
      #1;
      check("t2_ack_c2", 32'(bus.ext_ack), 32'h1);
      check("t2_we_c2", 32'(bus.ram_we), 32'h1);
      check("t2_addr_c2", 32'(bus.ram_addr), 32'h10);
      tick();
      set_ext(1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
      set_cpu(1'b1, 1'b0, 15'h0010, 16'h0000);
      #1;
      check("t2_back_cpu", 32'(bus.cpu_stall), 32'h0);
      check("t2_rd_data", 32'(bus.cpu_rdata), 32'h1234);
      tick();

      // 3: CPU busy every cycle, ext read held -> 4 CPU cycles, 1 ext, repeat
      set_cpu(1'b1, 1'b0, 15'h0010, 16'h0000);
      set_ext(1'b1, 1'b0, 1'b0, 15'h0005, 16'h0000);
      for (int c = 0; c < 10; c++) begin
         exp_ack = (c == 4) || (c == 9);
         #1;
         check($sformatf("t3_ack_c%0d", c), 32'(bus.ext_ack), 32'(exp_ack));
         check($sformatf("t3_stall_c%0d", c), 32'(bus.cpu_stall), 32'(exp_ack));
         check($sformatf("t4_nw_ack_c%0d", c), 32'(bus_nw.ext_ack), 32'h0);
         if (exp_ack) check("t3_ext_rdata", 32'(bus.ext_rdata), 32'hAAAA);
         tick();
      end

      // 4: MAX_WAIT=0 instance acks only once the CPU goes idle
      set_cpu(1'b0, 1'b0, 15'h0000, 16'h0000);
      #1;
      check("t4_nw_ack_idle0", 32'(bus_nw.ext_ack), 32'h0);
      check("t4_ack_idle0", 32'(bus.ext_ack), 32'h0);
      tick();
      #1;
      check("t4_nw_ack_idle1", 32'(bus_nw.ext_ack), 32'h1);
      check("t4_ack_idle1", 32'(bus.ext_ack), 32'h1);
      tick();
      set_ext(1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
      #1;
      tick();

      // dropping ext_req clears the starvation count
      req_pat = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
      set_cpu(1'b1, 1'b0, 15'h0000, 16'h0000);
      for (int c = 0; c < 8; c++) begin
         set_ext(req_pat[c][0], 1'b0, 1'b0, 15'h0005, 16'h0000);
         #1;
         check($sformatf("wclr_ack_c%0d", c), 32'(bus.ext_ack), 32'(c == 7));
         tick();
      end
      set_ext(1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
      #1;
      tick();

      // 6a: ext_req dropped during its grant cycle -> no ack, no write
      set_cpu(1'b0, 1'b0, 15'h0000, 16'h0000);
      set_ext(1'b1, 1'b1, 1'b0, 15'h0020, 16'hBEEF);
      #1;
      tick();
      bus.ext_req = 1'b0;
      #1;
      check("t6a_ack", 32'(bus.ext_ack), 32'h0);
      check("t6a_we", 32'(bus.ram_we), 32'h0);
      tick();
      set_ext(1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
      set_cpu(1'b1, 1'b0, 15'h0020, 16'h0000);
      #1;
      check("t6a_stall", 32'(bus.cpu_stall), 32'h0);
      check("t6a_rdata", 32'(bus.cpu_rdata), 32'h0);
      tick();

      // 6b: reset pulsed during an ext write grant
      set_cpu(1'b0, 1'b0, 15'h0000, 16'h0000);
      set_ext(1'b1, 1'b1, 1'b0, 15'h0030, 16'hCAFE);
      #1;
      check("t6b_ack_c1", 32'(bus.ext_ack), 32'h0);
      tick();
      #1;
      check("t6b_ack_c2", 32'(bus.ext_ack), 32'h1);
      rst_n = 1'b0;
      #1;
      check("t6b_rst_we", 32'(bus.ram_we), 32'h0);
      check("t6b_rst_ack", 32'(bus.ext_ack), 32'h0);
      tick();
      rst_n = 1'b1;
      set_ext(1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
      set_cpu(1'b1, 1'b0, 15'h0030, 16'h0000);
      #1;
      check("t6b_stall", 32'(bus.cpu_stall), 32'h0);
      check("t6b_rdata", 32'(bus.cpu_rdata), 32'h0);
      tick();

      // 5: 10 locked ext writes against a busy CPU
`ifdef RAM_ARB_BURST_EN
      exp_hist  = 20'h30FF0;
      exp_n     = 8'd10;
      last_addr = 15'h0049;
      last_data = 16'h5009;
`else
      exp_hist  = 20'h84210;
      exp_n     = 8'd4;
      last_addr = 15'h0043;
      last_data = 16'h5003;
`endif
      n    = 0;
      hist = '0;
      set_cpu(1'b1, 1'b0, 15'h0000, 16'h0000);
      for (int c = 0; c < 20; c++) begin
         set_ext(n < 10, 1'b1, n < 9, 15'(32'h40 + n), 16'(32'h5000 + n));
         #1;
         ack_now = bus.ext_ack;
         hist[c] = ack_now;
         check($sformatf("t5_stall_c%0d", c), 32'(bus.cpu_stall), 32'(ack_now));
         if (ack_now) n++;
         tick();
      end
      check("t5_ack_pattern", 32'(hist), 32'(exp_hist));
      check("t5_ack_count", 32'(n), 32'(exp_n));
      set_ext(1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
      set_cpu(1'b1, 1'b0, last_addr, 16'h0000);
      #1;
      check("t5_last_data", 32'(bus.cpu_rdata), 32'(last_data));
      set_cpu(1'b1, 1'b0, 15'h0040, 16'h0000);
      #1;
      check("t5_first_data", 32'(bus.cpu_rdata), 32'h5000);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
